// File: rtl/sst_pkg.sv
// Shared types and constants for the save-state initiator.
package sst_pkg;

  localparam int unsigned SST_REG_CNT  = 128;
  localparam int unsigned SST_IDX_ADDR = SST_REG_CNT - 1;
  localparam int unsigned SST_AW       = 8;

  typedef enum logic [3:0] {
    StIdle,
    StSAddr,
    StSCap,
    StLIrd,
    StLIchk,
    StLRd,
    StLLat,
    StLWait,
    StLHold,
    StFin
  } sst_state_t;

endpackage

// File: rtl/sst_m2_sync.sv
// Two-flop synchronizer for the CPU M2 clock with a falling-edge pulse.
module sst_m2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic m2_fall
);

  logic sync1_q, sync2_q, prev_q;

  // Flops reset to sampled-high so no spurious fall is flagged out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= m2;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign m2_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/sst_engine.sv
// Save-state initiator: dumps mapper registers into a buffer RAM (save) or
// replays buffer bytes into the mapper as M2-timed register writes (load).
module sst_engine
  import sst_pkg::*;
#(
  parameter int unsigned REG_CNT    = SST_REG_CNT,
  parameter int unsigned M2_TIMEOUT = 4096,
  parameter int unsigned M2_GUARD   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m2,
  input  logic              start_save,
  input  logic              start_load,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sst_act,
  output logic [SST_AW-1:0] sst_addr,
  output logic              sst_we_reg,
  output logic [SST_AW-1:0] sst_dato,
  input  logic [SST_AW-1:0] sst_di,
  output logic [SST_AW-1:0] buf_addr,
  output logic              buf_we,
  output logic [SST_AW-1:0] buf_do,
  input  logic [SST_AW-1:0] buf_di
);

  localparam int unsigned CntW = $clog2(M2_TIMEOUT + 1);
  localparam logic [SST_AW-1:0] IdxAddr  = SST_AW'(REG_CNT - 1);
  localparam logic [SST_AW-1:0] LastLoad = SST_AW'(REG_CNT - 2);
  localparam logic [CntW-1:0]   GuardCnt = CntW'(M2_GUARD);
  localparam logic [CntW-1:0]   LastCnt  = CntW'(M2_TIMEOUT - 1);

  sst_state_t        state_q, state_d;
  logic [SST_AW-1:0] idx_q, idx_d;
  logic [SST_AW-1:0] sst_addr_q, sst_addr_d;
  logic [SST_AW-1:0] buf_addr_q, buf_addr_d;
  logic [SST_AW-1:0] dato_q, dato_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              m2_fall;

  sst_m2_sync u_m2_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .m2     (m2),
    .m2_fall(m2_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      sst_addr_q <= '0;
      buf_addr_q <= '0;
      dato_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sst_addr_q <= sst_addr_d;
      buf_addr_q <= buf_addr_d;
      dato_q     <= dato_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sst_addr_d = sst_addr_q;
    buf_addr_d = buf_addr_q;
    dato_d     = dato_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_save) begin
          state_d    = StSAddr;
          idx_d      = '0;
          sst_addr_d = '0;
          buf_addr_d = '0;
          err_d      = 1'b0;
        end else if (start_load) begin
          state_d    = StLIrd;
          sst_addr_d = IdxAddr;
          buf_addr_d = IdxAddr;
          err_d      = 1'b0;
        end
      end
      StSAddr: state_d = StSCap;
      StSCap: begin
        if (idx_q == IdxAddr) begin
          state_d = StFin;
        end else begin
          idx_d      = idx_q + 8'd1;
          sst_addr_d = idx_q + 8'd1;
          buf_addr_d = idx_q + 8'd1;
          state_d    = StSAddr;
        end
      end
      StLIrd: state_d = StLIchk;
      StLIchk: begin
        if (buf_di != sst_di) begin
          err_set = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d      = '0;
          buf_addr_d = '0;
          state_d    = StLRd;
        end
      end
      StLRd: begin
        sst_addr_d = idx_q;
        state_d    = StLLat;
      end
      StLLat: begin
        dato_d  = buf_di;
        cnt_d   = '0;
        state_d = StLWait;
      end
      StLWait: begin
        cnt_d = cnt_q + 1'b1;
        // Falls seen inside the guard window may predate stable write data.
        if (m2_fall && (cnt_q >= GuardCnt)) begin
          state_d = StLHold;
        end else if (cnt_q == LastCnt) begin
          err_set = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StLHold: begin
        if (idx_q == LastLoad) begin
          state_d = StFin;
        end else begin
          idx_d      = idx_q + 8'd1;
          buf_addr_d = idx_q + 8'd1;
          state_d    = StLRd;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign sst_act    = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign err        = err_q | err_set;
  assign sst_addr   = sst_addr_q;
  assign buf_addr   = buf_addr_q;
  assign sst_we_reg = (state_q == StLLat) || (state_q == StLWait) || (state_q == StLHold);
  // Write data is live from the RAM in the latch cycle, then held in dato_q.
  assign sst_dato   = (state_q == StLLat) ? buf_di : dato_q;
  assign buf_we     = (state_q == StSCap);
  assign buf_do     = buf_we ? sst_di : '0;

endmodule

// File: tb/tb_sst_engine.sv
// Scoreboard bench for sst_engine with a behavioural mapper and buffer RAM.
module tb_sst_engine;

  localparam int unsigned REG_CNT    = 128;
  localparam int unsigned M2_TIMEOUT = 4096;
  localparam int unsigned M2_GUARD   = 3;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m2;
  logic       m2_hold = 1'b0;
  logic       start_save = 1'b0;
  logic       start_load = 1'b0;
  logic       busy, done, err, sst_act, sst_we_reg, buf_we;
  logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_do, buf_di;

  logic [7:0] mpat    [256];
  logic [7:0] mwr     [256];
  logic [7:0] exp_buf [256];
  logic [7:0] buf_mem [256];
  logic [7:0] map_idx = 8'h5D;

  exp_t save_q[$];
  exp_t ld_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   issued = 0;
  int   fall_cnt = 0;
  int   wr_idx_cnt = 0;
  bit   abort_ok = 1'b0;

  sst_engine #(
    .REG_CNT   (REG_CNT),
    .M2_TIMEOUT(M2_TIMEOUT),
    .M2_GUARD  (M2_GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2        (m2),
    .start_save(start_save),
    .start_load(start_load),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sst_act   (sst_act),
    .sst_addr  (sst_addr),
    .sst_we_reg(sst_we_reg),
    .sst_dato  (sst_dato),
    .sst_di    (sst_di),
    .buf_addr  (buf_addr),
    .buf_we    (buf_we),
    .buf_do    (buf_do),
    .buf_di    (buf_di)
  );

  initial forever #5 clk = ~clk;

  // M2 at 1/12 of clk, phase offset so its edges never line up with clk.
  initial begin
    m2 = 1'b1;
    #3;
    forever begin
      #60;
      m2 = m2_hold ? 1'b1 : ~m2;
    end
  end

  assign sst_di = (sst_addr == 8'(REG_CNT - 1)) ? map_idx : mpat[sst_addr];

  always @(posedge clk) begin
    if (buf_we) buf_mem[buf_addr] <= buf_do;
    buf_di <= buf_mem[buf_addr];
  end

  // Mapper latches a register write on the falling edge of M2.
  initial forever begin
    @(negedge m2);
    if (sst_act && sst_we_reg) begin
      mwr[sst_addr] = sst_dato;
      fall_cnt = fall_cnt + 1;
      if (sst_addr == 8'(REG_CNT - 1)) wr_idx_cnt = wr_idx_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv,
               expv, $time);
    end
  endtask

  // Monitor: pops the scoreboards on buffer writes and completed mapper strobes.
  initial begin
    logic       we_prev = 1'b0;
    logic [7:0] we_addr = '0;
    logic [7:0] we_dato = '0;
    int         falls0 = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (buf_we) begin
        chk("save_beat_expected", int'(save_q.size() != 0), 1);
        if (save_q.size() != 0) begin
          e = save_q.pop_front();
          chk("save_beat_addr", int'(buf_addr), e.addr);
          chk("save_beat_data", int'(buf_do), e.data);
        end
      end
      if (sst_we_reg && !we_prev) begin
        issued  = issued + 1;
        we_addr = sst_addr;
        we_dato = sst_dato;
        falls0  = fall_cnt;
      end else if (sst_we_reg) begin
        chk("strobe_stable", int'({sst_addr, sst_dato}), int'({we_addr, we_dato}));
      end else if (we_prev) begin
        if (!abort_ok) chk("strobe_expected", int'(ld_q.size() != 0), 1);
        if (ld_q.size() != 0) begin
          e = ld_q.pop_front();
          chk("load_addr", int'(we_addr), e.addr);
          chk("load_data", int'(we_dato), e.data);
          chk("load_mapper_reg", int'(mwr[e.addr]), e.data);
          chk("load_m2_fall_seen", int'(fall_cnt > falls0), 1);
        end
      end
      we_prev = sst_we_reg;
    end
  end

  task automatic pulse_start(input bit s, input bit l);
    @(negedge clk);
    start_save = s;
    start_load = l;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic run_save(input bit with_load);
    int         done_k;
    int         iss0;
    logic [7:0] v;
    for (int a = 0; a < REG_CNT; a++) begin
      v = (a == REG_CNT - 1) ? map_idx : mpat[a];
      exp_buf[a] = v;
      save_q.push_back('{addr: a, data: int'(v)});
    end
    iss0   = issued;
    done_k = -1;
    pulse_start(1'b1, with_load);
    chk("save_busy_c1", int'(busy), 1);
    chk("save_err_cleared", int'(err), 0);
    for (int k = 2; k <= 400; k++) begin
      @(negedge clk);
      start_load = (k == 50);
      if (done) begin
        done_k = k;
        break;
      end
    end
    start_load = 1'b0;
    chk("save_done_cycle", done_k, 2 * REG_CNT + 1);
    @(negedge clk);
    chk("save_done_pulse", int'(done), 0);
    chk("save_busy_end", int'(busy), 0);
    chk("save_no_strobe", issued - iss0, 0);
    chk("save_queue_drained", save_q.size(), 0);
    for (int a = 0; a < REG_CNT; a++) chk("save_buf_content", int'(buf_mem[a]), int'(exp_buf[a]));
  endtask

  task automatic run_load();
    int done_k;
    int iss0;
    int w0;
    for (int a = 0; a < REG_CNT - 1; a++) ld_q.push_back('{addr: a, data: int'(exp_buf[a])});
    iss0   = issued;
    w0     = wr_idx_cnt;
    done_k = -1;
    pulse_start(1'b0, 1'b1);
    for (int k = 1; k <= 8000; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
    end
    chk("load_done_seen", int'(done_k > 0), 1);
    @(negedge clk);
    chk("load_queue_drained", ld_q.size(), 0);
    chk("load_write_count", issued - iss0, REG_CNT - 1);
    chk("load_idx_never_written", wr_idx_cnt - w0, 0);
    chk("load_reg0", int'(mwr[0]), int'(exp_buf[0]));
    chk("load_err", int'(err), 0);
    chk("load_busy_end", int'(busy), 0);
    ld_q.delete();
  endtask

  initial begin
    int k_we;
    int k_err;
    int iss0;
    for (int a = 0; a < 256; a++) begin
      mpat[a] = 8'(a) ^ 8'h5A;
      mwr[a]  = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_act", int'(sst_act), 0);
    chk("rst_addr", int'(sst_addr), 0);
    chk("rst_we_reg", int'(sst_we_reg), 0);
    chk("rst_dato", int'(sst_dato), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_buf_we", int'(buf_we), 0);
    chk("rst_buf_do", int'(buf_do), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Save with both starts together (save wins) and a load request mid-save.
    map_idx = 8'h5D;
    run_save(1'b1);

    // Random mapper contents with 0x11 at register 0, then restore them.
    for (int a = 0; a < REG_CNT - 1; a++) mpat[a] = 8'($urandom_range(0, 255));
    mpat[0] = 8'h11;
    run_save(1'b0);
    run_load();

    // Index mismatch: err two cycles after start, no writes.
    map_idx = 8'h04;
    iss0 = issued;
    pulse_start(1'b0, 1'b1);
    chk("mis_busy_c1", int'(busy), 1);
    chk("mis_err_c1", int'(err), 0);
    @(negedge clk);
    chk("mis_err_c2", int'(err), 1);
    @(negedge clk);
    chk("mis_busy_c3", int'(busy), 0);
    chk("mis_err_sticky", int'(err), 1);
    repeat (20) @(negedge clk);
    chk("mis_no_writes", issued - iss0, 0);
    map_idx = 8'h5D;

    // M2 stuck high: write times out.
    m2_hold  = 1'b1;
    abort_ok = 1'b1;
    repeat (20) @(negedge clk);
    k_we  = -1;
    k_err = -1;
    pulse_start(1'b0, 1'b1);
    for (int k = 1; k <= int'(M2_TIMEOUT) + 100; k++) begin
      if (k > 1) @(negedge clk);
      if (sst_we_reg && k_we < 0) k_we = k;
      if (err) begin
        k_err = k;
        break;
      end
    end
    chk("tmo_we_cycle", k_we, 4);
    chk("tmo_err_delay", k_err - k_we, int'(M2_TIMEOUT));
    chk("tmo_we_at_err", int'(sst_we_reg), 1);
    @(negedge clk);
    chk("tmo_we_dropped", int'(sst_we_reg), 0);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_err_sticky", int'(err), 1);

    // Fresh save after an error must clear err on start.
    for (int a = 0; a < REG_CNT - 1; a++) mpat[a] = 8'($urandom_range(0, 255));
    run_save(1'b0);

    // Reset while waiting for M2.
    pulse_start(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (sst_we_reg) break;
    end
    repeat (5) @(negedge clk);
    chk("rst_mid_in_wait", int'(sst_we_reg), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_act", int'(sst_act), 0);
    chk("rst_mid_we_reg", int'(sst_we_reg), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_err", int'(err), 0);
    chk("rst_mid_addr", int'(sst_addr), 0);
    chk("rst_mid_dato", int'(sst_dato), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    m2_hold  = 1'b0;
    repeat (30) @(negedge clk);
    abort_ok = 1'b0;

    // Normal load must still work after the aborted one.
    run_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sst_engine.md
# sst_engine

Save-state initiator for the mapper save-state bus. On command it walks the mapper register space, dumping every byte the mapper returns into a local buffer RAM (save). It can also stream buffer bytes back into the mapper as register writes (load), after checking that the stored mapper index matches the running mapper. It sits between the system save-state controller and the active mapper module, and drives the same `sst` signals that mappers decode on the falling edge of M2.

## Interface
- `REG_CNT`, 128: number of save-state register addresses (0..REG_CNT-1); the last address holds the mapper index.
- `M2_TIMEOUT`, 4096: clk cycles allowed for an M2 falling edge before a load write is declared failed.
- `M2_GUARD`, 3: clk cycles after asserting a write before a detected M2 fall is accepted.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `m2`  in  1  CPU M2, asynchronous to `clk`.
- `start_save`  in  1  one-cycle request: dump mapper to buffer.
- `start_load`  in  1  one-cycle request: restore mapper from buffer.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag; cleared by the next accepted start.
- `sst_act`  out  1  save-state mode to the mapper.
- `sst_addr`  out  8  mapper register address.
- `sst_we_reg`  out  1  register write strobe (level, held across an M2 fall).
- `sst_dato`  out  8  write data to the mapper.
- `sst_di`  in  8  mapper read data, combinational from `sst_addr`.
- `buf_addr`  out  8  buffer RAM address.
- `buf_we`  out  1  buffer write enable.
- `buf_do`  out  8  buffer write data.
- `buf_di`  in  8  buffer read data, 1-cycle synchronous read.

## Operation
- States: IDLE, S_ADDR, S_CAP, L_IRD, L_ICHK, L_RD, L_LAT, L_WAIT, L_HOLD, FIN.
- IDLE: `start_save` → S_ADDR with idx=0. Else `start_load` → L_IRD. Save wins if both are asserted together. Starts are ignored while `busy`. An accepted start clears `err`.
- Save, per byte:
  - S_ADDR drives `sst_addr`=idx (settle cycle).
  - S_CAP asserts `buf_we`, with `buf_addr`=idx and `buf_do`=`sst_di`.
  - If idx==REG_CNT-1 → FIN. Else idx+1 → S_ADDR.
- Load index check:
  - L_IRD drives `buf_addr`=`sst_addr`=REG_CNT-1.
  - L_ICHK compares `buf_di` against `sst_di`.
  - On mismatch: set `err` → IDLE. No `sst_we_reg` is ever asserted in this case.
  - On match: idx=0 → L_RD.
- Load, per byte (idx 0..REG_CNT-2; the index byte is never written):
  - L_RD drives `buf_addr`=idx.
  - L_LAT registers `sst_dato`=`buf_di`, drives `sst_addr`=idx, asserts `sst_we_reg`.
  - L_WAIT holds everything and counts. An M2 fall is accepted only once the count ≥ M2_GUARD. Accepted fall → L_HOLD. Count reaching M2_TIMEOUT → `err`, deassert → IDLE.
  - L_HOLD keeps the write asserted one more cycle, then deasserts. If idx==REG_CNT-2 → FIN, else idx+1 → L_RD.
- FIN: `done` pulse for one cycle → IDLE.
- `sst_act` is 1 in every state except IDLE, and stays high through FIN.
- idx is 8 bits. REG_CNT must be ≤256, with no wrap inside an operation.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `sst_act`=0, `sst_addr`=0, `sst_we_reg`=0, `sst_dato`=0, `buf_addr`=0, `buf_we`=0, `buf_do`=0; state IDLE.
- Reset mid-operation: all outputs return to reset values at the reset edge. The write strobe drops immediately; the buffer is left partially written.
- Save latency: 2 cycles per byte. `done` goes high 2·REG_CNT+1 cycles after the start cycle.
- Load: 2 cycles for the index check, then per byte 2 + wait + 1 cycles. Wait time depends on M2 phase.
- M2 is synchronized by 2 flops. A fall is detected when the previous sampled value was 1 and the current value is 0. The guard means the mapper's real M2 edge always sees `sst_addr`/`sst_dato`/`sst_we_reg` stable for ≥1 clk beforehand. L_HOLD covers synchronizer lag after the real edge.
- `busy` is high from the cycle after the accepted start through FIN inclusive.

## Structure
- Shared package `sst_pkg`:
  - state enum `sst_state_t`
  - `SST_IDX_ADDR` (REG_CNT-1 default 127)
  - `SST_AW`=8
- Sub-module `sst_m2_sync`: 2-flop synchronizer plus falling-edge pulse (`clk`, `rst_n`, `m2` → `m2_fall`). Reset state is sampled-high, so no fall is flagged out of reset.

## Test plan
- Save with a behavioural mapper returning addr^0x5A, and 0x5D at address 127 → buffer holds the same bytes; `done` at cycle 257; no `sst_we_reg` pulse.
- Load with the buffer holding 0x11 at address 0 and 0x5D at 127, mapper index 0x5D, M2 at 1/12 clk → mapper register 0 latches 0x11 on an M2 fall; 127 writes issued in total; address 127 never written; `done` pulses.
- Load with buffer[127]=0x5D and mapper index 0x04 → `err`=1 two cycles after start; zero writes; `busy` returns to 0.
- Load with M2 held high → `err` after M2_TIMEOUT cycles in the first L_WAIT; `sst_we_reg` drops the next cycle.
- `start_save` and `start_load` in the same cycle → a save is performed; a `start_load` while busy is ignored.
- `rst_n` low during L_WAIT → next cycle `sst_act`=0, `sst_we_reg`=0, `busy`=0, `err`=0.
